// File: rtl/draw_arbiter_if.sv
// Requester and deck-side signal bundle for draw_arbiter.
// The master modport is the arbiter's view; the slave modport is the
// requesters' and deck's view.
interface draw_arbiter_if #(
  parameter int unsigned NUM_PLAYERS = 4
);
  localparam int unsigned PW = $clog2(NUM_PLAYERS);

  logic                       i_deal_start;
  logic [NUM_PLAYERS-1:0]     i_req;
  logic [3*NUM_PLAYERS-1:0]   i_req_cnt;
  logic [NUM_PLAYERS-1:0]     o_gnt;
  logic [2:0]                 o_deck_draw;
  logic                       i_deck_done;
  logic                       i_deck_drawn;
  logic [5:0]                 i_deck_card;
  logic                       o_card_valid;
  logic [5:0]                 o_card;
  logic [PW-1:0]              o_card_player;
  logic                       o_busy;
  logic                       o_deal_done;
  logic                       o_err;

  modport master (
    input  i_deal_start, i_req, i_req_cnt, i_deck_done, i_deck_drawn, i_deck_card,
    output o_gnt, o_deck_draw, o_card_valid, o_card, o_card_player,
           o_busy, o_deal_done, o_err
  );

  modport slave (
    output i_deal_start, i_req, i_req_cnt, i_deck_done, i_deck_drawn, i_deck_card,
    input  o_gnt, o_deck_draw, o_card_valid, o_card, o_card_player,
           o_busy, o_deal_done, o_err
  );
endinterface

// File: rtl/draw_arbiter.sv
// Card deck draw-port sequencer: runs the opening deal, then shares the
// deck between NUM_PLAYERS requesters round-robin and routes each card to
// its owner.
// Optional feature macro: DRAW_TIMEOUT_EN (watchdog abort with o_err pulse).
module draw_arbiter #(
  parameter int unsigned NUM_PLAYERS = 4,
  parameter int unsigned DEAL_CARDS  = 7,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  draw_arbiter_if.master bus
);
  localparam int unsigned PW = $clog2(NUM_PLAYERS);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned RW = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAW, S_GAP} state_t;

  state_t            state;
  logic              deal_mode;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     player;
  logic [RW-1:0]     round;
  logic [2:0]        code;
  logic [2:0]        remaining;

  logic [NUM_PLAYERS-1:0] req_ok;
  logic              gnt_found;
  logic [PW-1:0]     gnt_idx;
  logic [2:0]        gnt_code;
  logic [CW-1:0]     cand;

  // Out-of-range parameters stop elaboration
  if (NUM_PLAYERS < 2 || NUM_PLAYERS > 8 || DEAL_CARDS < 1 || DEAL_CARDS > 15 ||
      TIMEOUT < 1) begin : g_bad_params
    $error("draw_arbiter: parameter out of range");
  end

  // A request only counts with a one-hot count code
  always_comb begin
    req_ok = '0;
    for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
      req_ok[i] = bus.i_req[i] &&
                  (bus.i_req_cnt[3*i +: 3] inside {3'b001, 3'b010, 3'b100});
    end
  end

  // First valid requester at or after rr_ptr, wrapping
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_PLAYERS; k++) begin
      cand = {1'b0, rr_ptr} + CW'(k);
      if (cand >= CW'(NUM_PLAYERS)) cand = cand - CW'(NUM_PLAYERS);
      if (!gnt_found && req_ok[cand[PW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[PW-1:0];
      end
    end
  end

  // Count code of the winning requester
  always_comb begin
    gnt_code = 3'b000;
    for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
      if (gnt_idx == PW'(i)) gnt_code = bus.i_req_cnt[3*i +: 3];
    end
  end

`ifdef DRAW_TIMEOUT_EN
  localparam int unsigned WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wd_cnt;
  logic          wd_hit;

  // Watchdog expires on the cycle the count would reach TIMEOUT
  assign wd_hit = (state != S_IDLE) && !bus.i_deck_drawn && (wd_cnt == WW'(TIMEOUT - 1));
`endif

  // Sequencer state, deal counters and registered outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state             <= S_IDLE;
      deal_mode         <= 1'b0;
      rr_ptr            <= '0;
      player            <= '0;
      round             <= '0;
      code              <= 3'b000;
      remaining         <= 3'd0;
      bus.o_gnt         <= '0;
      bus.o_deck_draw   <= 3'b000;
      bus.o_card_valid  <= 1'b0;
      bus.o_card        <= 6'd0;
      bus.o_card_player <= '0;
      bus.o_busy        <= 1'b0;
      bus.o_deal_done   <= 1'b0;
      bus.o_err         <= 1'b0;
`ifdef DRAW_TIMEOUT_EN
      wd_cnt            <= '0;
`endif
    end else begin
      bus.o_gnt        <= '0;
      bus.o_card_valid <= 1'b0;
      bus.o_deal_done  <= 1'b0;
      bus.o_err        <= 1'b0;
`ifdef DRAW_TIMEOUT_EN
      // Cleared while idle, on entry to S_WAIT/S_DRAW and on every drawn card
      if (state == S_IDLE || bus.i_deck_drawn ||
          ((state == S_WAIT || state == S_GAP) && bus.i_deck_done)) begin
        wd_cnt <= '0;
      end else begin
        wd_cnt <= wd_cnt + WW'(1);
      end
`endif
      case (state)
        S_IDLE: begin
          if (bus.i_deal_start) begin
            deal_mode  <= 1'b1;
            player     <= '0;
            round      <= '0;
            state      <= S_WAIT;
            bus.o_busy <= 1'b1;
          end else if (gnt_found) begin
            deal_mode  <= 1'b0;
            player     <= gnt_idx;
            code       <= gnt_code;
            // A one-hot code's numeric value is its card count
            remaining  <= gnt_code;
            bus.o_gnt  <= NUM_PLAYERS'(1) << gnt_idx;
            rr_ptr     <= (gnt_idx == PW'(NUM_PLAYERS - 1)) ? '0 : gnt_idx + PW'(1);
            state      <= S_WAIT;
            bus.o_busy <= 1'b1;
          end
        end
        S_WAIT: begin
          if (bus.i_deck_done) begin
            if (deal_mode) begin
              code            <= 3'b001;
              remaining       <= 3'd1;
              bus.o_deck_draw <= 3'b001;
            end else begin
              bus.o_deck_draw <= code;
            end
            state <= S_DRAW;
          end
        end
        S_DRAW: begin
          if (bus.i_deck_drawn) begin
            bus.o_card_valid  <= 1'b1;
            bus.o_card        <= bus.i_deck_card;
            bus.o_card_player <= player;
            if (remaining != 3'd0) remaining <= remaining - 3'd1;
            if (remaining <= 3'd1) begin
              bus.o_deck_draw <= 3'b000;
              state           <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (bus.i_deck_done) begin
            if (!deal_mode) begin
              state      <= S_IDLE;
              bus.o_busy <= 1'b0;
            end else if (player == PW'(NUM_PLAYERS - 1)) begin
              player <= '0;
              if (round == RW'(DEAL_CARDS - 1)) begin
                round           <= '0;
                deal_mode       <= 1'b0;
                bus.o_deal_done <= 1'b1;
                state           <= S_IDLE;
                bus.o_busy      <= 1'b0;
              end else begin
                round <= round + RW'(1);
                state <= S_WAIT;
              end
            end else begin
              player <= player + PW'(1);
              state  <= S_WAIT;
            end
          end
        end
        default: begin
          state      <= S_IDLE;
          bus.o_busy <= 1'b0;
        end
      endcase
`ifdef DRAW_TIMEOUT_EN
      // Abort abandons whatever is left of the grant or deal
      if (wd_hit) begin
        bus.o_deck_draw <= 3'b000;
        bus.o_err       <= 1'b1;
        bus.o_busy      <= 1'b0;
        state           <= S_IDLE;
        deal_mode       <= 1'b0;
        remaining       <= 3'd0;
        player          <= '0;
        round           <= '0;
      end
`endif
    end
  end
endmodule

// File: tb/tb_draw_arbiter.sv
// Directed bench for draw_arbiter: opening deal, 4-card grant, round-robin,
// malformed codes, deck stall and mid-draw reset.
module tb_draw_arbiter;
  localparam int unsigned NP = 4;

  logic i_clk;
  logic i_rst_n;
  int   total;
  int   bad;
  int   deal_done_cnt;
  int   deal_done_at;
  int   err_cnt;

  logic [5:0] deck_q[$];
  logic [5:0] mon_card[$];
  logic [1:0] mon_player[$];

  draw_arbiter_if #(.NUM_PLAYERS(NP)) bus ();

  draw_arbiter #(
    .NUM_PLAYERS(NP),
    .DEAL_CARDS (7),
    .TIMEOUT    (255)
  ) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .bus    (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1);
  end

  // Collect delivered cards and pulse counts
  always @(negedge i_clk) begin
    if (bus.o_card_valid) begin
      mon_card.push_back(bus.o_card);
      mon_player.push_back(bus.o_card_player);
    end
    if (bus.o_deal_done) begin
      deal_done_cnt++;
      deal_done_at = mon_card.size();
    end
    if (bus.o_err) err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int p, input logic [2:0] c, input logic on);
    bus.i_req[p]           = on;
    bus.i_req_cnt[3*p +: 3] = c;
  endtask

  task automatic wait_gnt(input logic [3:0] exp, input string tag);
    int w = 0;
    do begin
      @(negedge i_clk);
      w++;
    end while (bus.o_gnt == 4'b0000 && w < 20);
    chk(tag, 32'(bus.o_gnt), 32'(exp));
    for (int i = 0; i < 4; i++) begin
      if (bus.o_gnt[i]) bus.i_req[i] = 1'b0;
    end
  endtask

  // Behaves as the deck: one card every other cycle, then back to done
  task automatic deck_serve(input int n, input logic [2:0] exp_code, input string tag);
    int w = 0;
    while (bus.o_deck_draw == 3'b000 && w < 40) begin
      @(negedge i_clk);
      w++;
    end
    chk(tag, 32'(bus.o_deck_draw), 32'(exp_code));
    bus.i_deck_done = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (k > 0) chk("draw_hold", 32'(bus.o_deck_draw), 32'(exp_code));
      bus.i_deck_drawn = 1'b1;
      bus.i_deck_card  = (deck_q.size() > 0) ? deck_q.pop_front() : 6'h00;
      @(negedge i_clk);
      bus.i_deck_drawn = 1'b0;
      @(negedge i_clk);
    end
    chk("draw_off", 32'(bus.o_deck_draw), 32'd0);
    bus.i_deck_done = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},   32'(bus.o_gnt), 32'd0);
    chk({tag, "_draw"},  32'(bus.o_deck_draw), 32'd0);
    chk({tag, "_cv"},    32'(bus.o_card_valid), 32'd0);
    chk({tag, "_card"},  32'(bus.o_card), 32'd0);
    chk({tag, "_cp"},    32'(bus.o_card_player), 32'd0);
    chk({tag, "_busy"},  32'(bus.o_busy), 32'd0);
    chk({tag, "_dd"},    32'(bus.o_deal_done), 32'd0);
    chk({tag, "_err"},   32'(bus.o_err), 32'd0);
  endtask

  initial begin
    int         w;
    int         cnt;
    logic [5:0] exp_cards [4];

    total = 0; bad = 0; deal_done_cnt = 0; deal_done_at = 0; err_cnt = 0;
    i_rst_n          = 1'b0;
    bus.i_deal_start = 1'b0;
    bus.i_req        = '0;
    bus.i_req_cnt    = '0;
    bus.i_deck_done  = 1'b1;
    bus.i_deck_drawn = 1'b0;
    bus.i_deck_card  = 6'h00;
    repeat (3) @(negedge i_clk);
    chk_all_zero("reset");
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Stray drawn pulse while idle is ignored
    bus.i_deck_drawn = 1'b1;
    bus.i_deck_card  = 6'h3F;
    @(negedge i_clk);
    bus.i_deck_drawn = 1'b0;
    @(negedge i_clk);
    chk("stray_drawn", 32'(mon_card.size()), 32'd0);

    // Opening deal, with a simultaneous request that must lose
    bus.i_deal_start = 1'b1;
    set_req(1, 3'b001, 1'b1);
    @(negedge i_clk);
    chk("deal_no_gnt", 32'(bus.o_gnt), 32'd0);
    chk("deal_busy", 32'(bus.o_busy), 32'd1);
    bus.i_deal_start = 1'b0;
    set_req(1, 3'b000, 1'b0);
    for (int k = 0; k < 28; k++) deck_q.push_back(6'(k));
    for (int k = 0; k < 28; k++) deck_serve(1, 3'b001, "deal_code");
    repeat (2) @(negedge i_clk);
    chk("deal_done_cnt", 32'(deal_done_cnt), 32'd1);
    chk("deal_done_at", 32'(deal_done_at), 32'd28);
    chk("deal_ncards", 32'(mon_card.size()), 32'd28);
    chk("deal_idle", 32'(bus.o_busy), 32'd0);
    if (mon_card.size() == 28) begin
      for (int k = 0; k < 28; k++) begin
        chk("deal_player", 32'(mon_player[k]), 32'(k % 4));
        chk("deal_card", 32'(mon_card[k]), 32'(k));
      end
    end
    mon_card.delete();
    mon_player.delete();

    // Player 2 asks for four cards
    exp_cards[0] = 6'h05; exp_cards[1] = 6'h13; exp_cards[2] = 6'h2C; exp_cards[3] = 6'h3E;
    set_req(2, 3'b100, 1'b1);
    wait_gnt(4'b0100, "p2_gnt");
    @(negedge i_clk);
    chk("p2_gnt_pulse", 32'(bus.o_gnt), 32'd0);
    chk("p2_latency", 32'(bus.o_deck_draw), 32'(3'b100));
    for (int k = 0; k < 4; k++) deck_q.push_back(exp_cards[k]);
    deck_serve(4, 3'b100, "p2_code");
    chk("p2_ncards", 32'(mon_card.size()), 32'd4);
    if (mon_card.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("p2_card", 32'(mon_card[k]), 32'(exp_cards[k]));
        chk("p2_player", 32'(mon_player[k]), 32'd2);
      end
    end
    mon_card.delete();
    mon_player.delete();

    // Multi-hot code from player 1 is never granted; player 3 is
    set_req(1, 3'b011, 1'b1);
    set_req(3, 3'b001, 1'b1);
    wait_gnt(4'b1000, "mh_gnt");
    deck_q.push_back(6'h21);
    deck_serve(1, 3'b001, "mh_code");
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge i_clk);
      if (bus.o_gnt != 4'b0000 || bus.o_busy) cnt++;
    end
    chk("mh_never", 32'(cnt), 32'd0);
    set_req(1, 3'b000, 1'b0);

    // Held requests from 0, 1, 3 with pointer at 0
    set_req(0, 3'b001, 1'b1);
    set_req(1, 3'b001, 1'b1);
    set_req(3, 3'b001, 1'b1);
    wait_gnt(4'b0001, "rr_first");
    deck_q.push_back(6'h01);
    deck_serve(1, 3'b001, "rr_code");
    wait_gnt(4'b0010, "rr_second");
    deck_q.push_back(6'h02);
    deck_serve(1, 3'b001, "rr_code");
    wait_gnt(4'b1000, "rr_third");
    deck_q.push_back(6'h03);
    deck_serve(1, 3'b001, "rr_code");
    set_req(0, 3'b010, 1'b1);
    set_req(3, 3'b001, 1'b1);
    wait_gnt(4'b0001, "rr_wrap");
    deck_q.push_back(6'h04);
    deck_q.push_back(6'h05);
    deck_serve(2, 3'b010, "rr_wrap_code");
    wait_gnt(4'b1000, "rr_after_wrap");
    deck_q.push_back(6'h06);
    deck_serve(1, 3'b001, "rr_code");
    mon_card.delete();
    mon_player.delete();

    // Deck never ready
    bus.i_deck_done = 1'b0;
    set_req(0, 3'b001, 1'b1);
    wait_gnt(4'b0001, "stall_gnt");
`ifdef DRAW_TIMEOUT_EN
    w = 0;
    do begin
      @(negedge i_clk);
      w++;
    end while (!bus.o_err && w < 400);
    chk("stall_err_cycle", 32'(w), 32'd255);
    chk("stall_err_draw", 32'(bus.o_deck_draw), 32'd0);
    chk("stall_err_busy", 32'(bus.o_busy), 32'd0);
    @(negedge i_clk);
    chk("stall_err_cnt", 32'(err_cnt), 32'd1);
    bus.i_deck_done = 1'b1;
`else
    cnt = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge i_clk);
      if (bus.o_deck_draw != 3'b000) cnt++;
    end
    chk("stall_draw", 32'(cnt), 32'd0);
    chk("stall_busy", 32'(bus.o_busy), 32'd1);
    chk("stall_err", 32'(err_cnt), 32'd0);
    bus.i_deck_done = 1'b1;
    deck_q.push_back(6'h11);
    deck_serve(1, 3'b001, "stall_resume");
`endif
    mon_card.delete();
    mon_player.delete();

    // Reset part-way through a two-card grant
    set_req(1, 3'b010, 1'b1);
    wait_gnt(4'b0010, "rst_gnt");
    w = 0;
    while (bus.o_deck_draw == 3'b000 && w < 40) begin
      @(negedge i_clk);
      w++;
    end
    chk("rst_code", 32'(bus.o_deck_draw), 32'(3'b010));
    bus.i_deck_done  = 1'b0;
    bus.i_deck_drawn = 1'b1;
    bus.i_deck_card  = 6'h0A;
    @(negedge i_clk);
    bus.i_deck_drawn = 1'b0;
    chk("rst_first_card", 32'(bus.o_card_valid), 32'd1);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    chk_all_zero("rst_mid");
    i_rst_n         = 1'b1;
    bus.i_deck_done = 1'b1;
    @(negedge i_clk);
    mon_card.delete();
    mon_player.delete();
    set_req(0, 3'b001, 1'b1);
    set_req(2, 3'b001, 1'b1);
    wait_gnt(4'b0001, "post_rst_gnt");
    deck_q.push_back(6'h2A);
    deck_serve(1, 3'b001, "post_rst_code");
    chk("post_rst_ncards", 32'(mon_card.size()), 32'd1);
    if (mon_card.size() == 1) begin
      chk("post_rst_card", 32'(mon_card[0]), 32'h2A);
      chk("post_rst_player", 32'(mon_player[0]), 32'd0);
    end
    wait_gnt(4'b0100, "post_rst_next");
    deck_q.push_back(6'h1B);
    deck_serve(1, 3'b001, "post_rst_code2");
    chk("final_idle", 32'(bus.o_busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
